// File: rtl/bf_pkg.sv
// Shared definitions for the stream multiplexer: selection modes and the
// select-width helper used wherever a channel index is carried.
package bf_pkg;

  localparam int MUX_MODE_SEL = 0;
  localparam int MUX_MODE_RR  = 1;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_if.sv
// Handshake bundle between N_IN upstream channels, the mux and one downstream
// consumer. The mux is the slave; the environment driving it is the master.
interface stream_mux_if #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4
);
  import bf_pkg::*;

  localparam int SEL_W = sel_w(N_IN);

  logic [SEL_W-1:0]      sel;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN-1:0]       in_ready;
  logic [N_IN*WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_src;

  modport master (
    output sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin grant: first requester at or above ptr, wrapping modulo N_IN.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter
  import bf_pkg::*;
#(
  parameter int N_IN = 4,
  localparam int SEL_W = sel_w(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             grant_vld,
  output logic [SEL_W-1:0] grant_idx
);

  logic             found_s;
  logic [SEL_W-1:0] idx_s;
  int               cand_s;

  // Scan the N_IN positions starting at ptr and latch the first requester.
  always_comb begin
    found_s = 1'b0;
    idx_s   = '0;
    cand_s  = 0;
    for (int i = 0; i < N_IN; i++) begin
      cand_s = (int'(ptr) + i) % N_IN;
      if (!found_s && req[cand_s]) begin
        found_s = 1'b1;
        idx_s   = SEL_W'(cand_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign grant_vld = found_s;
  assign grant_idx = idx_s;

endmodule

// File: rtl/stream_mux.sv
// N_IN-to-1 stream multiplexer with a single registered output stage.
// Channel choice is either an external sel or an internal round-robin pointer.
module stream_mux
  import bf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 4,
  parameter int MODE  = MUX_MODE_SEL
) (
  input  logic        clk,
  input  logic        rst,
  stream_mux_if.slave bus
);

  localparam int SEL_W = sel_w(N_IN);

  logic             load_en_s;
  logic [N_IN-1:0]  ready_s;
  logic [SEL_W-1:0] grant_idx_s;
  logic             xfer_s;
  logic [WIDTH-1:0] load_data_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_src_r;

  assign load_en_s = !out_valid_r || bus.out_ready;

  generate
    if (MODE == MUX_MODE_RR) begin : g_rr
      logic [SEL_W-1:0] rr_ptr_r;
      logic             grant_vld_s;
      logic [SEL_W-1:0] arb_idx_s;
      logic             unused_sel_s;

      assign unused_sel_s = ^bus.sel;

      rr_arbiter #(.N_IN(N_IN)) u_arb (
        .req       (bus.in_valid),
        .ptr       (rr_ptr_r),
        .grant_vld (grant_vld_s),
        .grant_idx (arb_idx_s)
      );

      assign grant_idx_s = arb_idx_s;

      // One-hot accept strobe for the arbitrated channel.
      always_comb begin
        ready_s = '0;
        for (int k = 0; k < N_IN; k++) begin
          if (!rst && load_en_s && grant_vld_s && (arb_idx_s == SEL_W'(k))) begin
            ready_s[k] = 1'b1;
          end else begin
            ready_s[k] = 1'b0;
          end
        end
      end

      // Pointer moves just past the winner only when a word is actually taken.
      always_ff @(posedge clk) begin
        if (rst) begin
          rr_ptr_r <= '0;
        end else if (xfer_s) begin
          if (int'(arb_idx_s) == N_IN - 1) begin
            rr_ptr_r <= '0;
          end else begin
            rr_ptr_r <= arb_idx_s + SEL_W'(1);
          end
        end else begin
          rr_ptr_r <= rr_ptr_r;
        end
      end
    end else begin : g_sel
      assign grant_idx_s = bus.sel;

      // Out-of-range sel matches no k, so nothing is accepted.
      always_comb begin
        ready_s = '0;
        for (int k = 0; k < N_IN; k++) begin
          if (!rst && load_en_s && (bus.sel == SEL_W'(k))) begin
            ready_s[k] = 1'b1;
          end else begin
            ready_s[k] = 1'b0;
          end
        end
      end
    end
  endgenerate

  assign xfer_s = |(ready_s & bus.in_valid);

  // ready_s is at most one-hot, so an AND-OR gather picks the granted word.
  always_comb begin
    load_data_s = '0;
    for (int k = 0; k < N_IN; k++) begin
      load_data_s = load_data_s | ({WIDTH{ready_s[k]}} & bus.in_data[k*WIDTH +: WIDTH]);
    end
  end

  // Output stage: load on transfer, drain on consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_src_r   <= '0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= load_data_s;
      out_src_r   <= grant_idx_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_src_r   <= out_src_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_src_r   <= out_src_r;
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_src   = out_src_r;

endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: SEL N=4, RR N=4 and SEL N=3 instances driven by
// directed vectors; per-instance scoreboards check every output handshake.
module tb_stream_mux;
  import bf_pkg::*;

  logic clk;
  logic rst;

  stream_mux_if #(.WIDTH(8), .N_IN(4)) s4 ();
  stream_mux_if #(.WIDTH(8), .N_IN(4)) r4 ();
  stream_mux_if #(.WIDTH(8), .N_IN(3)) s3 ();

  stream_mux #(.WIDTH(8), .N_IN(4), .MODE(MUX_MODE_SEL)) u_s4 (.clk(clk), .rst(rst), .bus(s4.slave));
  stream_mux #(.WIDTH(8), .N_IN(4), .MODE(MUX_MODE_RR))  u_r4 (.clk(clk), .rst(rst), .bus(r4.slave));
  stream_mux #(.WIDTH(8), .N_IN(3), .MODE(MUX_MODE_SEL)) u_s3 (.clk(clk), .rst(rst), .bus(s3.slave));

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Expected words: {src[3:0], data[7:0]}
  logic [11:0] q_s4[$];
  logic [11:0] q_r4[$];
  logic [11:0] q_s3[$];
  logic [11:0] e_s4, e_r4, e_s3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && s4.out_valid === 1'b1 && s4.out_ready === 1'b1) begin
      if (q_s4.size() == 0) begin
        total_cnt++;
        $display("FAIL s4_unexpected: got word 0x%0h from src %0d, expected none", s4.out_data, s4.out_src);
      end else begin
        e_s4 = q_s4.pop_front();
        chk("s4_src", 32'(s4.out_src), 32'(e_s4[11:8]));
        chk("s4_data", 32'(s4.out_data), 32'(e_s4[7:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && r4.out_valid === 1'b1 && r4.out_ready === 1'b1) begin
      if (q_r4.size() == 0) begin
        total_cnt++;
        $display("FAIL r4_unexpected: got word 0x%0h from src %0d, expected none", r4.out_data, r4.out_src);
      end else begin
        e_r4 = q_r4.pop_front();
        chk("r4_src", 32'(r4.out_src), 32'(e_r4[11:8]));
        chk("r4_data", 32'(r4.out_data), 32'(e_r4[7:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && s3.out_valid === 1'b1 && s3.out_ready === 1'b1) begin
      if (q_s3.size() == 0) begin
        total_cnt++;
        $display("FAIL s3_unexpected: got word 0x%0h from src %0d, expected none", s3.out_data, s3.out_src);
      end else begin
        e_s3 = q_s3.pop_front();
        chk("s3_src", 32'(s3.out_src), 32'(e_s3[11:8]));
        chk("s3_data", 32'(s3.out_data), 32'(e_s3[7:0]));
      end
    end
  end

  logic [3:0] rr_exp[3];

  initial begin
    rr_exp[0] = 4'b1000;
    rr_exp[1] = 4'b0001;
    rr_exp[2] = 4'b1000;

    // Reset with every channel requesting: nobody may be accepted.
    rst = 1'b1;
    s4.sel = 2'd0; s4.in_valid = 4'b1111; s4.in_data = 32'h44332211; s4.out_ready = 1'b1;
    r4.sel = 2'd0; r4.in_valid = 4'b1111; r4.in_data = 32'h44332211; r4.out_ready = 1'b1;
    s3.sel = 2'd0; s3.in_valid = 3'b111;  s3.in_data = 24'h332211;   s3.out_ready = 1'b1;
    tick(); tick();
    mid();
    chk("rst_s4_in_ready", 32'(s4.in_ready), 32'h0);
    chk("rst_r4_in_ready", 32'(r4.in_ready), 32'h0);
    chk("rst_s3_in_ready", 32'(s3.in_ready), 32'h0);
    chk("rst_r4_out_valid", 32'(r4.out_valid), 32'h0);
    chk("rst_r4_out_data", 32'(r4.out_data), 32'h0);
    chk("rst_s4_out_src", 32'(s4.out_src), 32'h0);
    tick();
    rst = 1'b0;
    s4.in_valid = 4'b0000; r4.in_valid = 4'b0000; s3.in_valid = 3'b000;

    // SEL: sel=2 picks 0xA5 with one-cycle latency.
    s4.sel = 2'd2; s4.in_valid = 4'b0100; s4.in_data = 32'h44A52211;
    q_s4.push_back({4'd2, 8'hA5});
    mid();
    chk("sel_in_ready", 32'(s4.in_ready), 32'b0100);
    tick();
    s4.in_valid = 4'b0000;
    mid();
    chk("sel_out_valid", 32'(s4.out_valid), 32'h1);
    chk("sel_out_data", 32'(s4.out_data), 32'hA5);
    chk("sel_out_src", 32'(s4.out_src), 32'h2);
    tick();
    mid();
    chk("drain_out_valid", 32'(s4.out_valid), 32'h0);
    chk("drain_data_hold", 32'(s4.out_data), 32'hA5);

    // Backpressure: hold 0x11 for 3 cycles, then consume and reload together.
    tick();
    s4.sel = 2'd0; s4.in_valid = 4'b0001; s4.in_data = 32'h44A55C11;
    q_s4.push_back({4'd0, 8'h11});
    mid();
    tick();
    s4.out_ready = 1'b0; s4.in_valid = 4'b1111; s4.sel = 2'd1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("bp_in_ready", 32'(s4.in_ready), 32'h0);
      chk("bp_out_data", 32'(s4.out_data), 32'h11);
      chk("bp_out_valid", 32'(s4.out_valid), 32'h1);
      tick();
    end
    s4.out_ready = 1'b1;
    q_s4.push_back({4'd1, 8'h5C});
    mid();
    chk("bp_release_in_ready", 32'(s4.in_ready), 32'b0010);
    tick();
    s4.in_valid = 4'b0000;
    mid();
    chk("bp_reload_valid", 32'(s4.out_valid), 32'h1);
    chk("bp_reload_data", 32'(s4.out_data), 32'h5C);
    tick();

    // RR: all channels requesting, one word per cycle in order 0..3,0..3.
    r4.in_data = 32'hC3C2C1C0; r4.in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      q_r4.push_back({4'(i % 4), 8'(8'hC0 + (i % 4))});
      mid();
      chk("rr_all_in_ready", 32'(r4.in_ready), 32'(1 << (i % 4)));
      tick();
    end
    r4.in_valid = 4'b0000;
    mid();
    tick();

    // RR: move pointer to 1, then 1001 alternates ch3, ch0, ch3.
    r4.in_data = 32'hD3D2D1D0; r4.in_valid = 4'b0001;
    q_r4.push_back({4'd0, 8'hD0});
    mid();
    chk("rr_ptr_setup", 32'(r4.in_ready), 32'b0001);
    tick();
    r4.in_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      q_r4.push_back(rr_exp[i] == 4'b1000 ? {4'd3, 8'hD3} : {4'd0, 8'hD0});
      mid();
      chk("rr_1001_in_ready", 32'(r4.in_ready), 32'(rr_exp[i]));
      tick();
    end
    r4.in_valid = 4'b0000;
    mid();
    tick();

    // Reset while holding 0x7E under backpressure: word discarded, pointer at 0.
    r4.in_data = 32'h33227E5A; r4.in_valid = 4'b0010;
    mid();
    chk("rst_load_in_ready", 32'(r4.in_ready), 32'b0010);
    tick();
    r4.out_ready = 1'b0; r4.in_valid = 4'b0000;
    mid();
    chk("full_7e_data", 32'(r4.out_data), 32'h7E);
    chk("full_7e_src", 32'(r4.out_src), 32'h1);
    tick();
    rst = 1'b1; r4.in_valid = 4'b1111;
    mid();
    chk("rst_mid_in_ready", 32'(r4.in_ready), 32'h0);
    tick();
    rst = 1'b0;
    mid();
    chk("post_rst_out_valid", 32'(r4.out_valid), 32'h0);
    chk("post_rst_out_data", 32'(r4.out_data), 32'h0);
    chk("post_rst_out_src", 32'(r4.out_src), 32'h0);
    chk("post_rst_ptr_ch0", 32'(r4.in_ready), 32'b0001);
    q_r4.push_back({4'd0, 8'h5A});
    tick();
    r4.in_valid = 4'b0000; r4.out_ready = 1'b1;
    mid();
    tick();

    // N_IN=3: sel=3 is out of range, nothing accepted; sel=2 still works.
    s3.sel = 2'd3; s3.in_valid = 3'b111; s3.in_data = 24'h3C2B1A;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("n3_oob_in_ready", 32'(s3.in_ready), 32'h0);
      chk("n3_oob_out_valid", 32'(s3.out_valid), 32'h0);
      tick();
    end
    s3.sel = 2'd2;
    q_s3.push_back({4'd2, 8'h3C});
    mid();
    chk("n3_sel2_in_ready", 32'(s3.in_ready), 32'b100);
    tick();
    s3.in_valid = 3'b000;
    mid();
    tick();
    tick();

    chk("s4_queue_drained", 32'(q_s4.size()), 32'h0);
    chk("r4_queue_drained", 32'(q_r4.size()), 32'h0);
    chk("s3_queue_drained", 32'(q_s3.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel.
REQ-002 Parameter N_IN, default 4, legal 2..16: number of input channels.
REQ-003 Parameter MODE, default MUX_MODE_SEL: MUX_MODE_SEL picks the channel by sel; MUX_MODE_RR picks by round-robin.
REQ-004 Derived constant SEL_W = max(1, clog2(N_IN)).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 sel  in  SEL_W  channel select; used in MUX_MODE_SEL only, ignored in MUX_MODE_RR.
REQ-008 in_valid  in  N_IN  per-channel data valid.
REQ-009 in_ready  out  N_IN  per-channel accept strobe.
REQ-010 in_data  in  N_IN*WIDTH  flattened inputs; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 out_valid  out  1  output register holds data.
REQ-012 out_ready  in  1  downstream accepts data.
REQ-013 out_data  out  WIDTH  registered data.
REQ-014 out_src  out  SEL_W  index of the channel that supplied out_data.

Function
REQ-015 The block has two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 load_en = !out_valid | out_ready.
REQ-017 A transfer occurs on channel k in a cycle where in_valid[k] & in_ready[k] are both high; at most one in_ready bit is high per cycle.
REQ-018 In MUX_MODE_SEL: in_ready[k] = load_en & (k == sel). If sel >= N_IN, no bit of in_ready is asserted.
REQ-019 In MUX_MODE_RR: the grant goes to the first channel with in_valid high, searching from rr_ptr upward and wrapping modulo N_IN. in_ready[grant] = load_en & any(in_valid).
REQ-020 In MUX_MODE_RR: on a transfer from channel g, rr_ptr <= (g+1) mod N_IN. With no transfer, rr_ptr holds.
REQ-021 On a transfer, the next edge loads in_data[g], sets out_src <= g and sets out_valid <= 1. Latency is 1 cycle from input handshake to out_valid.
REQ-022 In FULL with out_ready=1 and no transfer, the next edge clears out_valid; out_data and out_src hold their last values.
REQ-023 In FULL with out_ready=0: out_data, out_src and out_valid are held stable, and in_ready is all zeros.
REQ-024 A simultaneous output consume and input load in the same cycle stays in FULL with the new data. Sustained throughput is 1 word per cycle.
REQ-025 in_ready depends combinationally on in_valid (RR mode), sel and out_ready. Outputs out_* are registered only.
REQ-026 An in_valid bit that drops without a handshake has no effect.

Reset
REQ-027 While rst=1 at a rising edge: out_valid<=0, out_data<=0, out_src<=0, rr_ptr<=0.
REQ-028 in_ready is all zeros in any cycle where rst=1.
REQ-029 Reset asserted mid-transfer discards the held word; the downstream sees no handshake for that word.
REQ-030 The first grant after reset in MUX_MODE_RR starts the search at channel 0.

Structure
REQ-031 MUX_MODE_SEL=0 and MUX_MODE_RR=1 are defined in shared package bf_pkg. No other typedefs are required.
REQ-032 Round-robin grant logic is a sub-module rr_arbiter, parametrised by N_IN, with ports req, ptr, grant_vld and grant_idx. It is instantiated only when MODE=MUX_MODE_RR.
REQ-033 The block is a single output register stage with no internal FIFO. Target size is 120-400 lines of RTL including rr_arbiter.

Verification
REQ-034 SEL mode, N_IN=4, WIDTH=8: sel=2, in_valid=0100, in_data ch2=0xA5, out_ready=1. Required response: in_ready=0100, and on the next cycle out_valid=1, out_data=0xA5, out_src=2.
REQ-035 Backpressure: FULL with 0x11, out_ready=0 for 3 cycles, in_valid=1111. Required response: in_ready=0000 for those cycles and out_data stays 0x11. Then out_ready=1 gives a consume plus a new load in the same cycle.
REQ-036 RR mode, all in_valid=1111 for 8 cycles, out_ready=1. Required response: out_src sequence 0,1,2,3,0,1,2,3, one word per cycle.
REQ-037 RR mode, in_valid=1001, rr_ptr=1. Required response: grant to ch3, then ch0, then ch3.
REQ-038 Reset while FULL with 0x7E and out_ready=0. Required response: next cycle out_valid=0, out_data=0, out_src=0, and the RR pointer restarts at ch0.
REQ-039 Non-power-of-2 case, N_IN=3, SEL mode, sel=3, in_valid=111. Required response: in_ready=000 and out_valid stays 0.
